// File: rtl/display_pkg.sv
// Shared types and helpers for the segmented register display path.
package display_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts display cycles per segment; tick marks the last cycle of a dwell.
module dwell_timer
    import display_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = idx_w(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Shows a register value one segment at a time, MS first, with
// timed or stepped advance and a snapshot taken only at frame wrap.
module display_sequencer
    import display_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEG_W  = 16,
    parameter int DWELL  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                mode,
    input  logic                                step,
    input  logic [DATA_W-1:0]                   reg_data,
    output logic [SEG_W-1:0]                    seg_out,
    output logic [idx_w(DATA_W/SEG_W)-1:0]      seg_idx,
    output logic                                frame_done
);

    localparam int NSEG = DATA_W / SEG_W;
    localparam int IW   = idx_w(NSEG);
    localparam int BW   = idx_w(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSEG - 1);

    generate
        if ((DATA_W % SEG_W) != 0 || DWELL < 1) begin : g_bad_cfg
            $error("display_sequencer: bad DATA_W/SEG_W/DWELL");
        end
    endgenerate

    state_t            state;
    logic [DATA_W-1:0] shadow;
    logic              mode_q;
    logic              mode_chg;
    logic              running;
    logic              tick;
    logic              advance;
    logic [BW-1:0]     base;

    assign base    = BW'(DATA_W - 1 - int'(seg_idx) * SEG_W);
    assign seg_out = shadow[base -: SEG_W];

    // A mode switch restarts the dwell and suppresses any advance.
    assign mode_chg = (mode != mode_q);
    assign running  = (state == ST_RUN) && en;
    assign advance  = running && !mode_chg &&
                      ((mode == MODE_AUTO) ? tick : step);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!running || mode_chg || mode == MODE_MANUAL),
        .run   (running && mode == MODE_AUTO),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shadow     <= '0;
            seg_idx    <= '0;
            frame_done <= 1'b0;
            mode_q     <= MODE_AUTO;
        end else begin
            frame_done <= 1'b0;
            mode_q     <= mode;
            unique case (state)
                ST_IDLE: begin
                    seg_idx <= '0;
                    if (en) begin
                        shadow <= reg_data;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        seg_idx <= '0;
                    end else if (advance) begin
                        if (seg_idx == LAST_IDX) begin
                            seg_idx    <= '0;
                            shadow     <= reg_data;
                            frame_done <= 1'b1;
                        end else begin
                            seg_idx <= seg_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_sequencer.sv
// Directed checks of display_sequencer in two configurations.
module tb_display_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        en0 = 1'b0, mode0 = 1'b0, step0 = 1'b0;
    logic [31:0] data0 = '0;
    logic [15:0] seg0;
    logic        idx0;
    logic        fd0;

    logic        en1 = 1'b0, mode1 = 1'b0, step1 = 1'b0;
    logic [31:0] data1 = '0;
    logic [7:0]  seg1;
    logic [1:0]  idx1;
    logic        fd1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_sequencer u0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en0),
        .mode       (mode0),
        .step       (step0),
        .reg_data   (data0),
        .seg_out    (seg0),
        .seg_idx    (idx0),
        .frame_done (fd0)
    );

    display_sequencer #(
        .DATA_W (32),
        .SEG_W  (8),
        .DWELL  (3)
    ) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en1),
        .mode       (mode1),
        .step       (step1),
        .reg_data   (data1),
        .seg_out    (seg1),
        .seg_idx    (idx1),
        .frame_done (fd1)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (seg0 !== 16'h0 || idx0 !== 1'b0 || fd0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_u0: seg=%h idx=%0d fd=%b want 0 0 0",
                     seg0, idx0, fd0);
        end
        checks++;
        if (seg1 !== 8'h0 || idx1 !== 2'd0 || fd1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_u1: seg=%h idx=%0d fd=%b want 0 0 0",
                     seg1, idx1, fd1);
        end
        tick_clk();
        rst_n = 1'b1;
        tick_clk();
        checks++;
        if (seg0 !== 16'h0 || idx0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: seg=%h idx=%0d want 0 0",
                     seg0, idx0);
        end
    endtask

    task automatic test_alternate();
        logic [15:0] exp_seg;
        logic        exp_idx;
        logic        exp_fd;
        data0 = 32'hDEAD_BEEF;
        mode0 = 1'b0;
        en0   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick_clk();
            exp_idx = k[0];
            exp_seg = exp_idx ? 16'hBEEF : 16'hDEAD;
            exp_fd  = (k > 0) && !exp_idx;
            checks++;
            if (seg0 !== exp_seg || idx0 !== exp_idx || fd0 !== exp_fd) begin
                errors++;
                $display("FAIL alt[%0d]: seg=%h idx=%0d fd=%b want %h %0d %b",
                         k, seg0, idx0, fd0, exp_seg, exp_idx, exp_fd);
            end
        end
    endtask

    task automatic test_tear();
        int budget = 4;
        while (idx0 !== 1'b0 && budget > 0) begin
            tick_clk();
            budget--;
        end
        checks++;
        if (idx0 !== 1'b0) begin
            errors++;
            $display("FAIL tear_sync: idx=%0d want 0 (timeout)", idx0);
        end
        data0 = 32'hCAFE_F00D;
        tick_clk();
        checks++;
        if (seg0 !== 16'hBEEF || fd0 !== 1'b0) begin
            errors++;
            $display("FAIL tear_old: seg=%h fd=%b want BEEF 0", seg0, fd0);
        end
        tick_clk();
        checks++;
        if (seg0 !== 16'hCAFE || idx0 !== 1'b0 || fd0 !== 1'b1) begin
            errors++;
            $display("FAIL tear_wrap: seg=%h idx=%0d fd=%b want CAFE 0 1",
                     seg0, idx0, fd0);
        end
        tick_clk();
        checks++;
        if (seg0 !== 16'hF00D || fd0 !== 1'b0) begin
            errors++;
            $display("FAIL tear_new: seg=%h fd=%b want F00D 0", seg0, fd0);
        end
        en0 = 1'b0;
    endtask

    task automatic test_seg8_auto();
        logic [7:0] tbl [4];
        logic [7:0] exp_seg;
        logic [1:0] exp_idx;
        logic       exp_fd;
        tbl[0] = 8'h12;
        tbl[1] = 8'h34;
        tbl[2] = 8'h56;
        tbl[3] = 8'h78;
        data1 = 32'h1234_5678;
        mode1 = 1'b0;
        en1   = 1'b1;
        for (int e = 0; e < 26; e++) begin
            tick_clk();
            exp_idx = 2'((e / 3) % 4);
            exp_seg = tbl[exp_idx];
            exp_fd  = (e > 0) && (e % 12 == 0);
            checks++;
            if (seg1 !== exp_seg || idx1 !== exp_idx || fd1 !== exp_fd) begin
                errors++;
                $display("FAIL seg8[%0d]: seg=%h idx=%0d fd=%b want %h %0d %b",
                         e, seg1, idx1, fd1, exp_seg, exp_idx, exp_fd);
            end
        end
        en1 = 1'b0;
        tick_clk();
    endtask

    task automatic test_manual();
        logic [7:0] tbl [4];
        tbl[0] = 8'h34;
        tbl[1] = 8'h56;
        tbl[2] = 8'h78;
        tbl[3] = 8'hAA;
        mode1 = 1'b1;
        data1 = 32'h1234_5678;
        en1   = 1'b1;
        tick_clk();
        for (int c = 0; c < 10; c++) begin
            tick_clk();
            checks++;
            if (seg1 !== 8'h12 || fd1 !== 1'b0) begin
                errors++;
                $display("FAIL man_hold[%0d]: seg=%h fd=%b want 12 0",
                         c, seg1, fd1);
            end
        end
        data1 = 32'hAABB_CCDD;
        for (int s = 0; s < 4; s++) begin
            step1 = 1'b1;
            tick_clk();
            step1 = 1'b0;
            checks++;
            if (seg1 !== tbl[s] || fd1 !== (s == 3)) begin
                errors++;
                $display("FAIL man_step[%0d]: seg=%h fd=%b want %h %b",
                         s, seg1, fd1, tbl[s], s == 3);
            end
        end
        tick_clk();
        checks++;
        if (seg1 !== 8'hAA || idx1 !== 2'd0 || fd1 !== 1'b0) begin
            errors++;
            $display("FAIL man_after: seg=%h idx=%0d fd=%b want AA 0 0",
                     seg1, idx1, fd1);
        end
    endtask

    task automatic test_en_drop();
        step1 = 1'b1;
        tick_clk();
        tick_clk();
        step1 = 1'b0;
        checks++;
        if (seg1 !== 8'hCC || idx1 !== 2'd2) begin
            errors++;
            $display("FAIL drop_pre: seg=%h idx=%0d want CC 2", seg1, idx1);
        end
        en1   = 1'b0;
        step1 = 1'b1;
        tick_clk();
        step1 = 1'b0;
        checks++;
        if (seg1 !== 8'hAA || idx1 !== 2'd0 || fd1 !== 1'b0) begin
            errors++;
            $display("FAIL drop: seg=%h idx=%0d fd=%b want AA 0 0",
                     seg1, idx1, fd1);
        end
        tick_clk();
        checks++;
        if (seg1 !== 8'hAA || idx1 !== 2'd0) begin
            errors++;
            $display("FAIL drop_idle: seg=%h idx=%0d want AA 0", seg1, idx1);
        end
    endtask

    task automatic test_async_reset();
        mode1 = 1'b0;
        data0 = 32'hDEAD_BEEF;
        data1 = 32'h1234_5678;
        en0   = 1'b1;
        en1   = 1'b1;
        tick_clk();
        tick_clk();
        tick_clk();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg0 !== 16'h0 || idx0 !== 1'b0 || fd0 !== 1'b0) begin
            errors++;
            $display("FAIL arst_u0: seg=%h idx=%0d fd=%b want 0 0 0",
                     seg0, idx0, fd0);
        end
        checks++;
        if (seg1 !== 8'h0 || idx1 !== 2'd0 || fd1 !== 1'b0) begin
            errors++;
            $display("FAIL arst_u1: seg=%h idx=%0d fd=%b want 0 0 0",
                     seg1, idx1, fd1);
        end
        data0 = 32'h0123_4567;
        data1 = 32'h89AB_CDEF;
        #2;
        rst_n = 1'b1;
        tick_clk();
        checks++;
        if (seg0 !== 16'h0123 || seg1 !== 8'h89 || fd0 !== 1'b0) begin
            errors++;
            $display("FAIL arst_restart: seg0=%h seg1=%h fd0=%b want 0123 89 0",
                     seg0, seg1, fd0);
        end
        tick_clk();
        checks++;
        if (seg0 !== 16'h4567 || seg1 !== 8'h89 || idx1 !== 2'd0) begin
            errors++;
            $display("FAIL arst_next: seg0=%h seg1=%h idx1=%0d want 4567 89 0",
                     seg0, seg1, idx1);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_tear();
        test_seg8_auto();
        test_manual();
        test_en_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Parametrised successor to the two-half register display path.
- Splits a DATA_W-bit register value into NSEG = DATA_W/SEG_W segments and presents one segment at a time on a SEG_W-bit display bus.
- Adds a programmable dwell time, auto/manual stepping and tear-free frame snapshots.
- Sits between the register-file debug tap and the board display driver (LEDs / 7-segment).

Parameters:
- DATA_W, 32, width of the register value to display.
- SEG_W, 16, width of one displayed segment; DATA_W must be a multiple of SEG_W.
- DWELL, 1, clock cycles each segment is shown in auto mode; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; low forces IDLE.
- mode  input  1  0 = auto (timed advance), 1 = manual (advance on step).
- step  input  1  single-cycle advance pulse; used in manual mode only.
- reg_data  input  DATA_W  live register value.
- seg_out  output  SEG_W  currently displayed segment.
- seg_idx  output  max(1,$clog2(NSEG))  index of the displayed segment; 0 = most-significant.
- frame_done  output  1  one-cycle pulse when the last segment's display period ends.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; shadow = 0; seg_idx = 0; dwell cnt = 0; frame_done = 0.
  - seg_out is therefore 0.
- seg_out = shadow[DATA_W-1-seg_idx*SEG_W -: SEG_W]. This is a combinational mux of registered shadow and seg_idx, with no other logic.
- Segment order is MS first: index 0 = bits [DATA_W-1:DATA_W-SEG_W].
- IDLE:
  - en = 0 → stay; shadow holds; seg_idx = 0.
  - en = 1 at an edge → shadow <= reg_data; seg_idx <= 0; cnt <= 0; go RUN.
- RUN, auto (mode = 0):
  - cnt increments every edge.
  - When cnt == DWELL-1: cnt <= 0 and the segment advances.
  - Each segment is therefore visible exactly DWELL cycles.
- RUN, manual (mode = 1):
  - cnt held at 0.
  - step = 1 at an edge advances the segment.
  - step is ignored in auto mode.
- Advance rule:
  - seg_idx < NSEG-1 → seg_idx + 1.
  - seg_idx == NSEG-1 → seg_idx <= 0; shadow <= reg_data (snapshot only at frame boundary, so no tearing); frame_done <= 1 for exactly one cycle.
- frame_done is registered: it is high in the cycle in which seg_idx returns to 0.
- en = 0 in RUN:
  - Next edge: state <= IDLE; seg_idx <= 0; cnt <= 0; frame_done <= 0; shadow holds.
  - en has priority over a simultaneous step or dwell expiry.
- mode change mid-frame: cnt <= 0 at that edge; seg_idx preserved; no advance on the switching edge.
- Reset asserted mid-frame: all state returns to reset values immediately; operation resumes via IDLE.
- DWELL = 1 with NSEG = 2 gives per-cycle alternation of upper/lower halves, upper half first.
- NSEG = 1: every advance is a wrap, so shadow refreshes and frame_done pulses each period.
- Elaboration-time check: error if DATA_W % SEG_W != 0 or DWELL < 1.

Decomposition:
- Package display_pkg holds:
  - state encodings ST_IDLE / ST_RUN;
  - mode constants MODE_AUTO = 0 / MODE_MANUAL = 1;
  - width helper function for max(1,$clog2(n)).
- One sub-module, dwell_timer, parametrised by DWELL:
  - inputs clk, rst_n, clr, run;
  - output tick, high when cnt == DWELL-1 and run = 1.
  - The top FSM owns seg_idx, shadow and frame_done.

Test Plan:
1. Defaults, en = 1, mode = 0, reg_data = 0xDEAD_BEEF → seg_out alternates 0xDEAD, 0xBEEF each cycle; frame_done pulses every 2nd cycle, aligned with seg_idx = 0.
2. DATA_W = 32, SEG_W = 8, DWELL = 3, reg_data = 0x1234_5678 → 0x12, 0x34, 0x56, 0x78, each for 3 cycles; frame_done once per 12 cycles.
3. Tear check: change reg_data to 0xCAFE_F00D while seg_idx = 1 (defaults) → 0xBEEF still shown; 0xCAFE appears only after wrap.
4. Manual mode, SEG_W = 8: no step for 10 cycles → seg_out stays 0x12. Three step pulses → 0x34, 0x56, 0x78. Fourth step → 0x12 with frame_done = 1 and the new snapshot loaded.
5. en dropped while seg_idx = 2, with step asserted the same cycle → next cycle IDLE, seg_idx = 0, seg_out = MS segment of held shadow, frame_done = 0.
6. rst_n pulsed low asynchronously mid-dwell (between edges) → seg_out = 0, seg_idx = 0, frame_done = 0 immediately. After release with en = 1, the sequence restarts from segment 0 with a fresh snapshot.
